alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Registered, handshaked ALU for the 2A03/6502 datapath. Generalised in width, with optional
//  6502 decimal (BCD) mode, full N/V/Z/C flag generation and shift/rotate/inc/dec/BIT ops.
//  The control unit issues one operation at a time. Results and flags return over a
//  valid/ready pair. Sits between the register file/operand latches and the P-register update logic.
// PARAMETERS
//  WIDTH       8  operand/result width in bits; >=4; must be a multiple of 4 when DECIMAL_EN=1
//  DECIMAL_EN  0  1 enables the BCD adjust state for ADC/SBC; 0 (2A03 behaviour) ignores dec_mode
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      operation request
//  in_ready      out  1      block can accept a request (high only in IDLE)
//  op            in   4      opcode, see alu_pkg
//  a             in   WIDTH  operand A (accumulator side)
//  b             in   WIDTH  operand B (memory/immediate side)
//  carry_in      in   1      P.C
//  overflow_in   in   1      P.V
//  dec_mode      in   1      P.D
//  out_valid     out  1      result/flags valid
//  out_ready     in   1      consumer accepts result
//  f             out  WIDTH  result
//  negative      out  1      N flag
//  overflow      out  1      V flag
//  zero          out  1      Z flag
//  carry         out  1      C flag
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 in the cycle after reset; out_valid=0; f=0; N=V=Z=C=0.
//  Reset mid-operation: the in-flight operation is discarded, with no output pulse.
//  FSM: IDLE -(in_valid)-> EXEC -> ADJ (only if DECIMAL_EN && latched dec_mode && op in {ADC,SBC})
//       -> DONE; otherwise EXEC -> DONE. DONE -(out_ready)-> IDLE.
//  Accept edge k: a, b, op, carry_in, overflow_in, dec_mode are latched. Inputs are ignored afterwards.
//  Latency: binary ops: out_valid from cycle k+2. Decimal ADC/SBC: out_valid from cycle k+3.
//  DONE holds f and the flags stable while out_ready=0. Throughput is at most one op per 3 cycles.
//  in_valid while busy: ignored, and the request is not queued. The requester must hold in_valid.
//  Opcodes, with f as a WIDTH-bit result and C/V unchanged unless listed:
//   0 OR  a|b   1 AND a&b   2 EOR a^b
//   3 ADC {C,f}=a+b+cin; V=(a^f)&(b^f) at msb
//   4 ADD {C,f}=a+b (address calc, no cin); V as ADC
//   5 PASB f=b
//   6 CMP {C,f}=a+~b+1 (C=1 when a>=b unsigned); V unchanged
//   7 SBC {C,f}=a+~b+cin; V=(a^f)&(~b^f) at msb
//   8 ASL C=a[W-1], f=a<<1   9 LSR C=a[0], f=a>>1
//   A ROL f={a[W-2:0],cin}, C=a[W-1]   B ROR f={cin,a[W-1:1]}, C=a[0]
//   C INC f=a+1   D DEC f=a-1 (wraps at 0 / all-ones; C,V unchanged)
//   E BIT f=a; N=b[W-1]; V=b[W-2]; Z=((a&b)==0)
//   F reserved: f=a, all flags pass through unchanged
//  N=f[W-1] and Z=(f==0) for every op except BIT and F.
//  Decimal ADJ, one cycle, nibble-serial from LSB. ADC: nibble>9 or nibble carry -> +6, carry into next.
//   SBC: nibble borrow -> -6. C=final decimal carry/not-borrow. N, V, Z keep the binary-result values
//   (NMOS behaviour).
//  dec_mode is ignored when DECIMAL_EN=0, and for ops other than ADC/SBC.
// STRUCTURE
//  alu_pkg: opcode localparams OP_OR..OP_RSVD (4-bit), state encoding ST_IDLE/EXEC/ADJ/DONE.
//  Sub-module alu_bcd_adjust (combinational, WIDTH-generic nibble loop) is instantiated under
//  generate if DECIMAL_EN. Binary op mux and flag logic stay in alu_seq.
// TESTING
//  ADC a=8'h50 b=8'h50 cin=0 -> f=8'hA0, N=1 V=1 Z=0 C=0, out_valid 2 cycles after accept.
//  SBC a=8'h00 b=8'h01 cin=1 -> f=8'hFF, C=0 N=1 V=0; CMP a=8'h10 b=8'h10 -> Z=1 C=1, V=overflow_in.
//  DECIMAL_EN=1, dec_mode=1, ADC a=8'h58 b=8'h46 cin=1 -> f=8'h05, C=1, out_valid 3 cycles after accept.
//   Same stimulus with DECIMAL_EN=0 -> f=8'h9F, C=0.
//  ROR a=8'h01 cin=1 -> f=8'h80 C=1 N=1; BIT a=8'h0F b=8'hC0 -> Z=1 N=1 V=1, f=8'h0F.
//  Backpressure: out_ready=0 for 5 cycles -> f/flags stable, in_ready=0, a second in_valid is ignored.
//   Then out_ready=1 -> IDLE next cycle.
//  rst asserted during EXEC -> next cycle out_valid=0, in_ready=1, outputs 0.
//   WIDTH=16: INC 16'hFFFF -> f=0 Z=1 with C unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential 6502-style ALU.
package alu_pkg;

  localparam logic [3:0] OP_OR   = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_EOR  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_PASB = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_SBC  = 4'h7;
  localparam logic [3:0] OP_ASL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_BIT  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ADJ  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  // Only the two arithmetic ops that honour the D flag get a decimal fix-up pass.
  function automatic logic isDecimalOp(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             overflow_in;
  logic             dec_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             negative;
  logic             overflow;
  logic             zero;
  logic             carry;

  modport master (
    output in_valid, op, a, b, carry_in, overflow_in, dec_mode, out_ready,
    input  in_ready, out_valid, f, negative, overflow, zero, carry
  );

  modport slave (
    input  in_valid, op, a, b, carry_in, overflow_in, dec_mode, out_ready,
    output in_ready, out_valid, f, negative, overflow, zero, carry
  );

endinterface

// File: rtl/alu_bcd_adjust.sv
// Combinational nibble-serial BCD add/subtract; carry ripples from the LSB nibble upward.
module alu_bcd_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carryIn,
  input  logic             i_isSub,
  output logic [WIDTH-1:0] o_f,
  output logic             o_carry
);

  logic [4:0] w_digit;
  logic       w_chain;

  // For subtraction w_chain carries "not borrow", matching the 6502 C flag sense.
  always_comb begin
    o_f     = '0;
    w_digit = '0;
    w_chain = i_carryIn;
    for (int i = 0; i < WIDTH / 4; i++) begin
      if (i_isSub) begin
        w_digit = {1'b0, i_a[4*i +: 4]} - {1'b0, i_b[4*i +: 4]} - {4'b0000, ~w_chain};
        if (w_digit[4]) begin
          w_digit = w_digit - 5'd6;
          w_chain = 1'b0;
        end else begin
          w_chain = 1'b1;
        end
      end else begin
        w_digit = {1'b0, i_a[4*i +: 4]} + {1'b0, i_b[4*i +: 4]} + {4'b0000, w_chain};
        if (w_digit > 5'd9) begin
          w_digit = w_digit + 5'd6;
          w_chain = 1'b1;
        end else begin
          w_chain = 1'b0;
        end
      end
      o_f[4*i +: 4] = w_digit[3:0];
    end
    o_carry = w_chain;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 6502/2A03 ALU: latch operands, execute, optional BCD adjust, hold result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b0
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  alu_state_t       r_state;
  alu_state_t       w_nextState;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_vin;
  logic             r_dec;
  logic [WIDTH-1:0] r_f;
  logic             r_n;
  logic             r_v;
  logic             r_z;
  logic             r_c;

  logic [WIDTH-1:0] w_addB;
  logic             w_addCin;
  logic [WIDTH:0]   w_sum;
  logic             w_addOvf;
  logic [WIDTH-1:0] w_binF;
  logic             w_binN;
  logic             w_binV;
  logic             w_binZ;
  logic             w_binC;
  logic [WIDTH-1:0] w_bcdF;
  logic             w_bcdC;
  logic             w_useAdj;

  assign w_useAdj = DECIMAL_EN && r_dec && isDecimalOp(r_op);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_nextState = ST_EXEC;
      ST_EXEC: w_nextState = w_useAdj ? ST_ADJ : ST_DONE;
      ST_ADJ:  w_nextState = ST_DONE;
      ST_DONE: if (bus.out_ready) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // One shared adder serves ADC, ADD, CMP and SBC; subtraction is a + ~b + carry.
  always_comb begin
    w_addB   = r_b;
    w_addCin = r_cin;
    case (r_op)
      OP_ADD:  w_addCin = 1'b0;
      OP_CMP:  begin w_addB = ~r_b; w_addCin = 1'b1; end
      OP_SBC:  w_addB = ~r_b;
      default: ;
    endcase
  end

  assign w_sum    = {1'b0, r_a} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_addCin};
  assign w_addOvf = (r_a[WIDTH-1] ^ w_sum[WIDTH-1]) & (w_addB[WIDTH-1] ^ w_sum[WIDTH-1]);

  always_comb begin
    w_binF = r_a;
    w_binC = r_cin;
    w_binV = r_vin;
    case (r_op)
      OP_OR:   w_binF = r_a | r_b;
      OP_AND:  w_binF = r_a & r_b;
      OP_EOR:  w_binF = r_a ^ r_b;
      OP_ADC, OP_ADD, OP_SBC: begin
        w_binF = w_sum[WIDTH-1:0];
        w_binC = w_sum[WIDTH];
        w_binV = w_addOvf;
      end
      OP_PASB: w_binF = r_b;
      OP_CMP:  begin w_binF = w_sum[WIDTH-1:0]; w_binC = w_sum[WIDTH]; end
      OP_ASL:  begin w_binF = {r_a[WIDTH-2:0], 1'b0};  w_binC = r_a[WIDTH-1]; end
      OP_LSR:  begin w_binF = {1'b0, r_a[WIDTH-1:1]};  w_binC = r_a[0]; end
      OP_ROL:  begin w_binF = {r_a[WIDTH-2:0], r_cin}; w_binC = r_a[WIDTH-1]; end
      OP_ROR:  begin w_binF = {r_cin, r_a[WIDTH-1:1]}; w_binC = r_a[0]; end
      OP_INC:  w_binF = r_a + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC:  w_binF = r_a - {{(WIDTH-1){1'b0}}, 1'b1};
      default: ;
    endcase
    w_binN = w_binF[WIDTH-1];
    w_binZ = (w_binF == '0);
    // BIT reports memory bits 7/6 and the AND test; the reserved op leaves N/Z as they were.
    if (r_op == OP_BIT) begin
      w_binN = r_b[WIDTH-1];
      w_binV = r_b[WIDTH-2];
      w_binZ = ((r_a & r_b) == '0);
    end else if (r_op == OP_RSVD) begin
      w_binN = r_n;
      w_binZ = r_z;
    end
  end

  generate
    if (DECIMAL_EN) begin : g_bcd
      alu_bcd_adjust #(.WIDTH(WIDTH)) u_bcdAdjust (
        .i_a       (r_a),
        .i_b       (r_b),
        .i_carryIn (r_cin),
        .i_isSub   (r_op == OP_SBC),
        .o_f       (w_bcdF),
        .o_carry   (w_bcdC)
      );
    end else begin : g_noBcd
      assign w_bcdF = r_a;
      assign w_bcdC = r_cin;
    end
  endgenerate

  // N, V and Z come from the binary pass; the ADJ pass only replaces f and C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_vin <= 1'b0;
      r_dec <= 1'b0;
      r_f   <= '0;
      r_n   <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_op  <= bus.op;
          r_a   <= bus.a;
          r_b   <= bus.b;
          r_cin <= bus.carry_in;
          r_vin <= bus.overflow_in;
          r_dec <= bus.dec_mode;
        end
        ST_EXEC: begin
          r_f <= w_binF;
          r_n <= w_binN;
          r_v <= w_binV;
          r_z <= w_binZ;
          r_c <= w_binC;
        end
        ST_ADJ: begin
          r_f <= w_bcdF;
          r_c <= w_bcdC;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.f         = r_f;
  assign bus.negative  = r_n;
  assign bus.overflow  = r_v;
  assign bus.zero      = r_z;
  assign bus.carry     = r_c;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: three instances (8-bit decimal, 8-bit binary-only, 16-bit).
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] f;
    logic        n;
    logic        v;
    logic        z;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  ifA ();
  alu_seq_if #(.WIDTH(8))  ifB ();
  alu_seq_if #(.WIDTH(16)) ifC ();

  alu_seq #(.WIDTH(8),  .DECIMAL_EN(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  alu_seq #(.WIDTH(8),  .DECIMAL_EN(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b0)) dutC (.clk(clk), .rst(rst), .bus(ifC));

  logic [2:0]  reqValid = 3'b000;
  logic [2:0]  outReady = 3'b111;
  logic [3:0]  op   = 4'h0;
  logic [15:0] opA  = 16'h0;
  logic [15:0] opB  = 16'h0;
  logic        cin  = 1'b0;
  logic        vin  = 1'b0;
  logic        dec  = 1'b0;

  assign ifA.in_valid = reqValid[0]; assign ifB.in_valid = reqValid[1]; assign ifC.in_valid = reqValid[2];
  assign ifA.out_ready = outReady[0]; assign ifB.out_ready = outReady[1]; assign ifC.out_ready = outReady[2];
  assign ifA.op = op; assign ifB.op = op; assign ifC.op = op;
  assign ifA.a = opA[7:0]; assign ifB.a = opA[7:0]; assign ifC.a = opA;
  assign ifA.b = opB[7:0]; assign ifB.b = opB[7:0]; assign ifC.b = opB;
  assign ifA.carry_in = cin; assign ifB.carry_in = cin; assign ifC.carry_in = cin;
  assign ifA.overflow_in = vin; assign ifB.overflow_in = vin; assign ifC.overflow_in = vin;
  assign ifA.dec_mode = dec; assign ifB.dec_mode = dec; assign ifC.dec_mode = dec;

  logic [2:0]  inReady;
  logic [2:0]  outValid;
  logic [15:0] obsF    [3];
  logic [3:0]  obsNvzc [3];

  assign inReady  = {ifC.in_ready, ifB.in_ready, ifA.in_ready};
  assign outValid = {ifC.out_valid, ifB.out_valid, ifA.out_valid};
  assign obsF[0] = {8'h00, ifA.f};
  assign obsF[1] = {8'h00, ifB.f};
  assign obsF[2] = ifC.f;
  assign obsNvzc[0] = {ifA.negative, ifA.overflow, ifA.zero, ifA.carry};
  assign obsNvzc[1] = {ifB.negative, ifB.overflow, ifB.zero, ifB.carry};
  assign obsNvzc[2] = {ifC.negative, ifC.overflow, ifC.zero, ifC.carry};

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t mk(input logic [15:0] f, input logic [3:0] nvzc);
    exp_t e;
    e.f = f;
    {e.n, e.v, e.z, e.c} = nvzc;
    return e;
  endfunction

  task automatic expectEq(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Pops the oldest expectation for unit u and compares it with what the DUT presents.
  task automatic checkOutput(input int u);
    exp_t e;
    logic haveExp;
    e       = '0;
    haveExp = 1'b0;
    case (u)
      0: if (qA.size() > 0) begin e = qA.pop_front(); haveExp = 1'b1; end
      1: if (qB.size() > 0) begin e = qB.pop_front(); haveExp = 1'b1; end
      default: if (qC.size() > 0) begin e = qC.pop_front(); haveExp = 1'b1; end
    endcase
    total++;
    if (!haveExp) begin
      bad++;
      $display("[TB] FAIL unexpected-output u%0d: got f=%h nvzc=%b, want no output", u, obsF[u], obsNvzc[u]);
    end else if (obsF[u] !== e.f || obsNvzc[u] !== {e.n, e.v, e.z, e.c}) begin
      bad++;
      $display("[TB] FAIL result u%0d: got f=%h nvzc=%b, want f=%h nvzc=%b",
               u, obsF[u], obsNvzc[u], e.f, {e.n, e.v, e.z, e.c});
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (outValid[u] === 1'b1 && outReady[u]) checkOutput(u);
    end
  end

  // Issues one op on unit u, queues its expected result, and checks accept-to-valid latency.
  task automatic applyStimulus(input int u, input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                               input logic ci, input logic vi, input logic dm, input exp_t e, input int lat);
    int n;
    @(negedge clk);
    op = o; opA = aa; opB = bb; cin = ci; vin = vi; dec = dm;
    reqValid[u] = 1'b1;
    n = 0;
    while (!inReady[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady[u]) begin
      total++;
      bad++;
      $display("[TB] FAIL accept-timeout u%0d op=%h: got in_ready=0, want 1", u, o);
      reqValid[u] = 1'b0;
      return;
    end
    case (u)
      0: qA.push_back(e);
      1: qB.push_back(e);
      default: qC.push_back(e);
    endcase
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      reqValid[u] = 1'b0;
      n++;
    end while (!outValid[u] && n < 10);
    expectEq($sformatf("latency u%0d op=%h", u, o), n, lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      expectEq($sformatf("reset in_ready u%0d", u), inReady[u], 1);
      expectEq($sformatf("reset out_valid u%0d", u), outValid[u], 0);
      expectEq($sformatf("reset f u%0d", u), obsF[u], 0);
      expectEq($sformatf("reset flags u%0d", u), obsNvzc[u], 0);
    end
    rst = 1'b0;

    // Unit 0: binary ops (dec_mode=0) with hand-computed results; flags packed as N,V,Z,C.
    applyStimulus(0, OP_ADC,  16'h50, 16'h50, 0, 0, 0, mk(16'hA0, 4'b1100), 2);
    applyStimulus(0, OP_SBC,  16'h00, 16'h01, 1, 1, 0, mk(16'hFF, 4'b1000), 2);
    applyStimulus(0, OP_CMP,  16'h10, 16'h10, 0, 1, 0, mk(16'h00, 4'b0111), 2);
    applyStimulus(0, OP_CMP,  16'h10, 16'h20, 1, 0, 0, mk(16'hF0, 4'b1000), 2);
    applyStimulus(0, OP_ROR,  16'h01, 16'h00, 1, 0, 0, mk(16'h80, 4'b1001), 2);
    applyStimulus(0, OP_BIT,  16'h0F, 16'hC0, 0, 0, 0, mk(16'h0F, 4'b1110), 2);
    applyStimulus(0, OP_ASL,  16'h81, 16'h00, 0, 0, 0, mk(16'h02, 4'b0001), 2);
    applyStimulus(0, OP_LSR,  16'h01, 16'h00, 0, 1, 0, mk(16'h00, 4'b0111), 2);
    applyStimulus(0, OP_ROL,  16'h80, 16'h00, 1, 0, 0, mk(16'h01, 4'b0001), 2);
    applyStimulus(0, OP_OR,   16'h0F, 16'hF0, 1, 0, 0, mk(16'hFF, 4'b1001), 2);
    applyStimulus(0, OP_AND,  16'h0F, 16'hF0, 0, 1, 0, mk(16'h00, 4'b0110), 2);
    applyStimulus(0, OP_EOR,  16'hFF, 16'h0F, 0, 0, 0, mk(16'hF0, 4'b1000), 2);
    applyStimulus(0, OP_ADD,  16'h80, 16'h80, 1, 0, 0, mk(16'h00, 4'b0111), 2);
    applyStimulus(0, OP_PASB, 16'h12, 16'h7F, 1, 1, 0, mk(16'h7F, 4'b0101), 2);
    applyStimulus(0, OP_DEC,  16'h00, 16'h00, 1, 1, 0, mk(16'hFF, 4'b1101), 2);
    applyStimulus(0, OP_INC,  16'h7F, 16'h00, 0, 0, 0, mk(16'h80, 4'b1000), 2);

    // Unit 0: decimal mode takes the extra ADJ cycle only for ADC/SBC.
    applyStimulus(0, OP_ADC,  16'h58, 16'h46, 1, 0, 1, mk(16'h05, 4'b1101), 3);
    applyStimulus(0, OP_SBC,  16'h46, 16'h12, 1, 0, 1, mk(16'h34, 4'b0001), 3);
    applyStimulus(0, OP_OR,   16'h01, 16'h02, 0, 0, 1, mk(16'h03, 4'b0000), 2);

    // Unit 1 ignores dec_mode; unit 2 checks 16-bit wrap and carry pass-through.
    applyStimulus(1, OP_ADC,  16'h58, 16'h46, 1, 0, 1, mk(16'h9F, 4'b1100), 2);
    applyStimulus(2, OP_INC,  16'hFFFF, 16'h0, 1, 0, 0, mk(16'h0000, 4'b0011), 2);
    applyStimulus(2, OP_INC,  16'hFFFF, 16'h0, 0, 1, 0, mk(16'h0000, 4'b0110), 2);
    applyStimulus(2, OP_ADC,  16'h7FFF, 16'h1, 0, 0, 0, mk(16'h8000, 4'b1100), 2);

    // Backpressure: result must hold while out_ready=0 and a second request is ignored.
    @(posedge clk);
    #1 outReady[0] = 1'b0;
    applyStimulus(0, OP_ADC, 16'h70, 16'h20, 0, 0, 0, mk(16'h90, 4'b1100), 2);
    for (int i = 0; i < 5; i++) begin
      expectEq("bp f", obsF[0], 16'h90);
      expectEq("bp flags", obsNvzc[0], 4'b1100);
      expectEq("bp in_ready", inReady[0], 0);
      expectEq("bp out_valid", outValid[0], 1);
      if (i == 1) begin
        op = OP_PASB; opA = 16'h00; opB = 16'h00EE; cin = 1'b1; vin = 1'b1;
        reqValid[0] = 1'b1;
      end
      if (i == 3) reqValid[0] = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1 outReady[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expectEq("bp release in_ready", inReady[0], 1);
    expectEq("bp release out_valid", outValid[0], 0);

    // Reset while the op is in EXEC: no output pulse, outputs cleared.
    @(negedge clk);
    op = OP_EOR; opA = 16'hAA; opB = 16'h55; cin = 1'b0; vin = 1'b0; dec = 1'b0;
    reqValid[0] = 1'b1;
    @(negedge clk);
    reqValid[0] = 1'b0;
    expectEq("mid-op in_ready", inReady[0], 0);
    rst = 1'b1;
    @(negedge clk);
    expectEq("mid-reset out_valid", outValid[0], 0);
    expectEq("mid-reset in_ready", inReady[0], 1);
    expectEq("mid-reset f", obsF[0], 0);
    expectEq("mid-reset flags", obsNvzc[0], 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      expectEq("post-reset out_valid", outValid[0], 0);
    end

    repeat (4) @(negedge clk);
    expectEq("pending expectations", qA.size() + qB.size() + qC.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
